// File: rtl/replica_pkg.sv
// Shared types and constants for the replica-exchange units.
// Holds the exchange command encoding, the default distance type and the
// xorshift64 shift constants plus a one-step helper.
package replica_pkg;

  localparam int unsigned XS_SHIFT_A   = 13;
  localparam int unsigned XS_SHIFT_B   = 7;
  localparam int unsigned XS_SHIFT_C   = 17;
  localparam int unsigned TOTAL_W_DFLT = 32;

  typedef enum logic [1:0] {
    EX_NOP  = 2'd0,
    EX_PREV = 2'd1,
    EX_FOLW = 2'd2
  } exchange_command_t;

  typedef logic [TOTAL_W_DFLT-1:0] total_data_t;

  // One xorshift64 step (13/7/17).
  function automatic logic [63:0] xs_next(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << XS_SHIFT_A);
    y = y ^ (y >> XS_SHIFT_B);
    y = y ^ (y << XS_SHIFT_C);
    return y;
  endfunction

endpackage

// File: rtl/xorshift64.sv
// xorshift64 random source with seed load and single-step advance.
// Ports: clk, reset (sync, active-high), init (load seed, wins over advance),
//        seed (0 is replaced by 1), advance (step once), state (current value).
module xorshift64
  import replica_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic [63:0] seed,
  input  logic        advance,
  output logic [63:0] state
);

  logic [63:0] state_q, state_d;

  // All-zero state is a fixed point of xorshift, so never load it.
  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = (seed == 64'd0) ? 64'd1 : seed;
    end else if (advance) begin
      state_d = xs_next(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= 64'd1;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/replica_pair_tester.sv
// Replica-exchange test/command unit for one sub-node of the chain.
// Pair parity alternates each round; the pair leader computes
// w=(E_self-E_folw)*dbeta, decides with its RNG and passes the decision to
// its follower. Both then issue one-cycle exchange commands on exchange_run.
// Ports: clk/reset; random_init/random_seed (RNG load); dbeta; replica_run
//        (start test); exchange_run (apply); self_dis/folw_dis (distances);
//        prev_dec_vld/prev_dec (from leader ID-1); out_dec_vld/out_dec (to
//        ID+1); ex_com/ex_com_vld (command strobe); busy; parity;
//        accept_cnt/attempt_cnt (saturating stats); err (sticky protocol error).
module replica_pair_tester
  import replica_pkg::*;
#(
  parameter int unsigned ID          = 0,
  parameter int unsigned REPLICA_NUM = 32,
  parameter int unsigned TOTAL_W     = 32,
  parameter int unsigned DBETA_W     = 16,
  parameter int unsigned FRAC_W      = 8,
  parameter int unsigned MUL_LAT     = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   random_init,
  input  logic [63:0]            random_seed,
  input  logic [DBETA_W-1:0]     dbeta,
  input  logic                   replica_run,
  input  logic                   exchange_run,
  input  logic [TOTAL_W-1:0]     self_dis,
  input  logic [TOTAL_W-1:0]     folw_dis,
  input  logic                   prev_dec_vld,
  input  logic                   prev_dec,
  output logic                   out_dec_vld,
  output logic                   out_dec,
  output exchange_command_t      ex_com,
  output logic                   ex_com_vld,
  output logic                   busy,
  output logic                   parity,
  output logic [CNT_W-1:0]       accept_cnt,
  output logic [CNT_W-1:0]       attempt_cnt,
  output logic                   err
);

  localparam int unsigned D_W = TOTAL_W + 1;
  localparam int unsigned W_W = TOTAL_W + DBETA_W + 1;
  localparam int unsigned P_W = TOTAL_W + DBETA_W + 2;
  localparam logic ID_ODD   = 1'(ID % 2);
  localparam logic HAS_FOLW = (ID + 1 < REPLICA_NUM);
  localparam logic HAS_PREV = (ID >= 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DECIDE, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [TOTAL_W-1:0]    self_q, self_d, folw_q, folw_d;
  logic                  dec_q, dec_d, seen_q, seen_d;
  logic                  out_dec_vld_q, out_dec_vld_d, out_dec_q, out_dec_d;
  exchange_command_t     ex_com_q, ex_com_d;
  logic                  ex_com_vld_q, ex_com_vld_d;
  logic                  parity_q, parity_d, busy_q, busy_d, err_q, err_d;
  logic [CNT_W-1:0]      acc_q, acc_d, att_q, att_d;
  logic signed [W_W-1:0] mul_q [MUL_LAT];
  logic signed [W_W-1:0] mul_d [MUL_LAT];

  logic                  leader_c, follower_c, rng_adv_c;
  logic [63:0]           rng_state;

  // Role for the current round follows from parity and chain position.
  assign leader_c   = (ID_ODD == parity_q) && HAS_FOLW;
  assign follower_c = (ID_ODD != parity_q) && HAS_PREV;

  xorshift64 u_rng (
    .clk     (clk),
    .reset   (reset),
    .init    (random_init),
    .seed    (random_seed),
    .advance (rng_adv_c),
    .state   (rng_state)
  );

  // Single signed multiply on captured operands; the delay line lets
  // synthesis retime it across MUL_LAT stages.
  logic signed [D_W-1:0] diff_c;
  logic signed [P_W-1:0] prod_c;
  assign diff_c = $signed({1'b0, self_q}) - $signed({1'b0, folw_q});
  assign prod_c = P_W'(diff_c) * P_W'($signed({1'b0, dbeta}));

  always_comb begin
    mul_d[0] = W_W'(prod_c);
    for (int i = 1; i < int'(MUL_LAT); i++) begin
      mul_d[i] = mul_q[i-1];
    end
  end

  // Metropolis test: accept with probability 2^-k, k = floor(-w / 2^FRAC_W).
  logic signed [W_W-1:0] w_c;
  logic [W_W-1:0]        neg_w_c, k_full_c;
  logic [5:0]            k_c;
  logic [63:0]           mask_c;
  logic                  accept_c;
  assign w_c      = mul_q[MUL_LAT-1];
  assign neg_w_c  = -w_c;
  assign k_full_c = neg_w_c >> FRAC_W;
  assign k_c      = (k_full_c > W_W'(63)) ? 6'd63 : k_full_c[5:0];
  assign mask_c   = (64'd1 << k_c) - 64'd1;
  assign accept_c = !w_c[W_W-1] || ((rng_state & mask_c) == 64'd0);

  // Follower decision may arrive in the same cycle as exchange_run.
  logic seen_now_c, fol_dec_now_c;
  assign seen_now_c    = seen_q || prev_dec_vld;
  assign fol_dec_now_c = prev_dec_vld ? prev_dec : dec_q;

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    self_d        = self_q;
    folw_d        = folw_q;
    dec_d         = dec_q;
    seen_d        = seen_q;
    out_dec_vld_d = 1'b0;
    out_dec_d     = out_dec_q;
    ex_com_d      = EX_NOP;
    ex_com_vld_d  = 1'b0;
    parity_d      = parity_q;
    err_d         = err_q;
    acc_d         = acc_q;
    att_d         = att_q;
    rng_adv_c     = 1'b0;

    if (follower_c && (state_q != S_IDLE) && prev_dec_vld) begin
      dec_d  = prev_dec;
      seen_d = 1'b1;
    end

    if (replica_run && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end

    // Early exchange: NOP strobe, parity still advances, round abandoned.
    if (exchange_run && (state_q != S_HOLD)) begin
      ex_com_vld_d = 1'b1;
      parity_d     = ~parity_q;
      err_d        = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!exchange_run && replica_run) begin
          dec_d  = 1'b0;
          seen_d = 1'b0;
          cnt_d  = 2'd0;
          if (leader_c) begin
            self_d  = self_dis;
            folw_d  = folw_dis;
            state_d = S_CALC;
          end else if (follower_c) begin
            state_d = S_CALC;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(MUL_LAT - 1)) begin
          state_d = S_DECIDE;
        end
        if (exchange_run) begin
          state_d = S_IDLE;
        end
      end
      S_DECIDE: begin
        state_d = exchange_run ? S_IDLE : S_HOLD;
        if (leader_c) begin
          out_dec_vld_d = 1'b1;
          out_dec_d     = accept_c;
          dec_d         = accept_c;
          rng_adv_c     = 1'b1;
          if (att_q != '1) begin
            att_d = att_q + CNT_W'(1);
          end
          if (accept_c && (acc_q != '1)) begin
            acc_d = acc_q + CNT_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (exchange_run) begin
          state_d      = S_IDLE;
          ex_com_vld_d = 1'b1;
          parity_d     = ~parity_q;
          if (leader_c) begin
            if (dec_q) begin
              ex_com_d = EX_FOLW;
            end
          end else if (follower_c) begin
            if (!seen_now_c) begin
              err_d = 1'b1;
            end else if (fol_dec_now_c) begin
              ex_com_d = EX_PREV;
            end
          end
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      self_q        <= '0;
      folw_q        <= '0;
      dec_q         <= 1'b0;
      seen_q        <= 1'b0;
      out_dec_vld_q <= 1'b0;
      out_dec_q     <= 1'b0;
      ex_com_q      <= EX_NOP;
      ex_com_vld_q  <= 1'b0;
      parity_q      <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      acc_q         <= '0;
      att_q         <= '0;
      for (int i = 0; i < int'(MUL_LAT); i++) begin
        mul_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      self_q        <= self_d;
      folw_q        <= folw_d;
      dec_q         <= dec_d;
      seen_q        <= seen_d;
      out_dec_vld_q <= out_dec_vld_d;
      out_dec_q     <= out_dec_d;
      ex_com_q      <= ex_com_d;
      ex_com_vld_q  <= ex_com_vld_d;
      parity_q      <= parity_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      acc_q         <= acc_d;
      att_q         <= att_d;
      for (int i = 0; i < int'(MUL_LAT); i++) begin
        mul_q[i] <= mul_d[i];
      end
    end
  end

  assign out_dec_vld = out_dec_vld_q;
  assign out_dec     = out_dec_q;
  assign ex_com      = ex_com_q;
  assign ex_com_vld  = ex_com_vld_q;
  assign busy        = busy_q;
  assign parity      = parity_q;
  assign accept_cnt  = acc_q;
  assign attempt_cnt = att_q;
  assign err         = err_q;

endmodule

// File: tb/tb_replica_pair_tester.sv
// Bench for replica_pair_tester: a three-node chain (IDs 0..2) sharing
// stimulus, checked against a round-level reference model of roles,
// Metropolis decisions, RNG sequence, counters and commands.
module tb_replica_pair_tester;
  import replica_pkg::*;

  localparam int unsigned N       = 3;
  localparam int unsigned TOTAL_W = 32;
  localparam int unsigned DBETA_W = 16;
  localparam int unsigned FRAC_W  = 8;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int          CMAX    = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic random_init = 1'b0;
  logic [63:0] random_seed = 64'd0;
  logic [DBETA_W-1:0] dbeta = '0;
  logic replica_run = 1'b0;
  logic exchange_run = 1'b0;
  logic [TOTAL_W-1:0] self_dis = '0;
  logic [TOTAL_W-1:0] folw_dis = '0;

  logic [N-1:0] dvld, dec, exv, busy, par, err, pvld, pdec;
  logic [1:0]       exc [N];
  logic [CNT_W-1:0] acc [N];
  logic [CNT_W-1:0] att [N];

  assign pvld = {dvld[N-2:0], 1'b0};
  assign pdec = {dec[N-2:0], 1'b0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_node
    replica_pair_tester #(
      .ID(g), .REPLICA_NUM(N), .TOTAL_W(TOTAL_W), .DBETA_W(DBETA_W),
      .FRAC_W(FRAC_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .random_init  (random_init),
      .random_seed  (random_seed),
      .dbeta        (dbeta),
      .replica_run  (replica_run),
      .exchange_run (exchange_run),
      .self_dis     (self_dis),
      .folw_dis     (folw_dis),
      .prev_dec_vld (pvld[g]),
      .prev_dec     (pdec[g]),
      .out_dec_vld  (dvld[g]),
      .out_dec      (dec[g]),
      .ex_com       (exc[g]),
      .ex_com_vld   (exv[g]),
      .busy         (busy[g]),
      .parity       (par[g]),
      .accept_cnt   (acc[g]),
      .attempt_cnt  (att[g]),
      .err          (err[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit [63:0] m_rng [N];
  int        m_acc [N];
  int        m_att [N];
  bit        m_err [N];
  bit        m_par;

  function automatic int role(int id, bit p);
    if ((id % 2) == int'(p) && id + 1 < int'(N)) return 1;
    if ((id % 2) != int'(p) && id >= 1) return 2;
    return 0;
  endfunction

  function automatic bit [63:0] xs(bit [63:0] x);
    x = x ^ (x << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  function automatic bit m_accept(longint s, longint f, longint db, bit [63:0] r);
    longint w, k;
    bit [63:0] mask;
    w = (s - f) * db;
    if (w >= 0) return 1'b1;
    k = (-w) / (longint'(1) << FRAC_W);
    if (k > 63) k = 63;
    mask = (64'd1 << k) - 64'd1;
    return (r & mask) == 64'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) begin
      m_rng[i] = 64'd1; m_acc[i] = 0; m_att[i] = 0; m_err[i] = 1'b0;
    end
    m_par = 1'b0;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < int'(N); i++) begin
      check({tag, "_par"}, 64'(par[i]), 64'(m_par));
      check({tag, "_acc"}, 64'(acc[i]), 64'(m_acc[i]));
      check({tag, "_att"}, 64'(att[i]), 64'(m_att[i]));
      check({tag, "_err"}, 64'(err[i]), 64'(m_err[i]));
      check({tag, "_busy"}, 64'(busy[i]), 64'd0);
    end
  endtask

  task automatic do_round(input logic [31:0] s, input logic [31:0] f,
                          input logic [15:0] db, input int gap);
    bit a [N];
    int lead, lat;
    logic got_dec;
    logic [1:0] exp_com;
    @(negedge clk);
    self_dis = s; folw_dis = f; dbeta = db; replica_run = 1'b1;
    @(negedge clk);
    replica_run = 1'b0;
    for (int i = 0; i < int'(N); i++) check("busy_run", 64'(busy[i]), 64'd1);
    lead = -1;
    for (int i = 0; i < int'(N); i++) begin
      a[i] = 1'b0;
      if (role(i, m_par) == 1) begin
        lead = i;
        a[i] = m_accept(longint'({32'd0, s}), longint'({32'd0, f}),
                        longint'({48'd0, db}), m_rng[i]);
        m_rng[i] = xs(m_rng[i]);
        if (m_att[i] < CMAX) m_att[i]++;
        if (a[i] && m_acc[i] < CMAX) m_acc[i]++;
      end
    end
    lat = -1;
    got_dec = 1'bx;
    for (int c = 1; c <= int'(MUL_LAT) + 4; c++) begin
      @(negedge clk);
      if (lead >= 0 && dvld[lead] && lat < 0) begin
        lat = c;
        got_dec = dec[lead];
      end
    end
    check("dec_lat", 64'(lat), 64'(MUL_LAT + 1));
    check("out_dec", 64'(got_dec), 64'(a[lead]));
    repeat (gap) @(negedge clk);
    exchange_run = 1'b1;
    @(negedge clk);
    exchange_run = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      exp_com = 2'(EX_NOP);
      if (role(i, m_par) == 1 && a[i]) exp_com = 2'(EX_FOLW);
      if (role(i, m_par) == 2 && a[i-1]) exp_com = 2'(EX_PREV);
      check("ex_vld", 64'(exv[i]), 64'd1);
      check("ex_com", 64'(exc[i]), 64'(exp_com));
    end
    m_par = ~m_par;
    check_state("round");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] s, f;
    logic [15:0] db;
    int mode;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      check("rst_excom", 64'(exc[i]), 64'(EX_NOP));
      check("rst_exvld", 64'(exv[i]), 64'd0);
      check("rst_dvld", 64'(dvld[i]), 64'd0);
    end
    check_state("rst");

    // Zero seed must load as 1; first k=1 test then rejects (rng[0]=1).
    @(negedge clk);
    random_seed = 64'd0; random_init = 1'b1;
    @(negedge clk);
    random_init = 1'b0;
    do_round(32'd50, 32'd306, 16'd1, 0);
    check("k1_golden_dec0", 64'(dec[0]), 64'd0);
    do_round(32'd100, 32'd50, 16'd1, 1);
    do_round(32'd100, 32'd50, 16'd1, 2);
    check("accept_dir", 64'(exc[0]), 64'(EX_FOLW));

    @(negedge clk);
    random_seed = {$urandom, $urandom}; random_init = 1'b1;
    for (int i = 0; i < int'(N); i++) m_rng[i] = (random_seed == 64'd0) ? 64'd1 : random_seed;
    @(negedge clk);
    random_init = 1'b0;

    for (int r = 0; r < 48; r++) begin
      s = $urandom;
      mode = $urandom_range(0, 3);
      case (mode)
        0: f = $urandom;
        1: f = s - 32'($urandom_range(0, 3000));
        2: f = s + 32'($urandom_range(0, 3000));
        default: f = s;
      endcase
      db = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8));
      do_round(s, f, db, $urandom_range(0, 2));
    end
    check("att_sat0", 64'(att[0]), 64'(CMAX));

    // Back-to-back replica_run, then exchange_run while still calculating.
    @(negedge clk);
    replica_run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    replica_run = 1'b0; exchange_run = 1'b1;
    @(negedge clk);
    exchange_run = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      check("early_vld", 64'(exv[i]), 64'd1);
      check("early_com", 64'(exc[i]), 64'(EX_NOP));
      m_err[i] = 1'b1;
    end
    m_par = ~m_par;
    check_state("early");

    // Reset in the middle of a calculation.
    @(negedge clk);
    replica_run = 1'b1;
    @(negedge clk);
    replica_run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < int'(N); i++) check("rst_no_excom", 64'(exv[i]), 64'd0);
      @(negedge clk);
    end
    check_state("midrst");
    do_round(32'd50, 32'd306, 16'd1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
